cnet_dma_xfer_ctrl: RTL
=======================

CNET_DMA_XFER_CTRL -- requirements
Module: cnet_dma_xfer_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 1023, idle cycles inside an active transfer before abort (10-bit counter).
REQ-002 SHALL have port: clk  input  1  single clock for all logic.
REQ-003 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: pkt_avail  input  1  egress queue holds a complete packet; show-ahead.
REQ-005 SHALL have port: pkt_len  input  11  egress packet byte length; valid while pkt_avail.
REQ-006 SHALL have port: pkt_data  input  32  current egress word; show-ahead.
REQ-007 SHALL have port: pkt_rd  output  1  pop one egress word.
REQ-008 SHALL have port: cpci_rd_rdy  output  1  packet available for CPCI read.
REQ-009 SHALL have port: dma_rd_req  input  1  CPCI starts a read (length fetch).
REQ-010 SHALL have port: dma_rd_en  input  1  CPCI consumes dma_data_to_cpci this cycle.
REQ-011 SHALL have port: dma_data_to_cpci  output  32  length word, then packet data.
REQ-012 SHALL have port: dma_rd_last  output  1  current data word is last of packet.
REQ-013 SHALL have port: dma_wr_start  input  1  CPCI starts a write; dma_wr_size valid.
REQ-014 SHALL have port: dma_wr_size  input  11  write byte length.
REQ-015 SHALL have port: dma_wr_vld  input  1  dma_data_frm_cpci valid.
REQ-016 SHALL have port: dma_data_frm_cpci  input  32  write data word.
REQ-017 SHALL have port: cpci_wr_rdy  output  1  block accepts dma_wr_start.
REQ-018 SHALL have port: in_full  input  1  ingress lacks space for one 2047-byte packet.
REQ-019 SHALL have port: in_wr / in_data / in_eop / in_be  output  1/32/1/4  ingress word strobe, data, end-of-packet, byte enables (active-high, byte 0 = bits 7:0).
REQ-020 SHALL have port: xfer_err  output  1  one-cycle pulse on rejected or aborted transfer.

Function
REQ-021 SHALL implement states IDLE, RD_LEN, RD_DATA, WR_DATA, DRAIN.
REQ-022 SHALL compute word count = len[10:2] + (|len[1:0]), 9-bit, loaded into one shared down-counter.
REQ-023 SHALL drive cpci_rd_rdy = IDLE && pkt_avail && pkt_len!=0; cpci_wr_rdy = IDLE && !in_full.
REQ-024 IDLE: dma_wr_start && cpci_wr_rdy -> WR_DATA (write priority over simultaneous dma_rd_req, which is ignored); else dma_rd_req && cpci_rd_rdy -> RD_LEN.
REQ-025 dma_wr_start with dma_wr_size==0 SHALL be ignored and pulse xfer_err next cycle; state stays IDLE.
REQ-026 RD_LEN: dma_data_to_cpci = {21'b0, pkt_len} (combinational); dma_rd_en -> RD_DATA, counter loaded.
REQ-027 RD_DATA: dma_data_to_cpci = pkt_data; pkt_rd = dma_rd_en; counter decrements per dma_rd_en; dma_rd_last = (counter==1).
REQ-028 RD_DATA: dma_rd_en with counter==1 -> IDLE.
REQ-029 WR_DATA: each dma_wr_vld registers one ingress word (1-cycle latency): in_wr=1, in_data=dma_data_frm_cpci, in_eop=(counter==1), in_be=4'b1111 except last word.
REQ-030 Last-word in_be from size[1:0]: 00->1111, 01->0001, 10->0011, 11->0111; captured at dma_wr_start.
REQ-031 WR_DATA: dma_wr_vld with counter==1 -> IDLE; in_full ignored during WR_DATA (space guaranteed at start).
REQ-032 dma_rd_en outside RD_LEN/RD_DATA and dma_wr_vld outside WR_DATA SHALL be ignored.
REQ-033 Idle timer: reset on entry to any active state and on each dma_rd_en/dma_wr_vld; increments otherwise in RD_LEN/RD_DATA/WR_DATA.
REQ-034 Timer == TIMEOUT_CYCLES in RD_LEN/RD_DATA -> DRAIN, xfer_err pulse; DRAIN asserts pkt_rd each cycle, decrementing counter (RD_LEN loads full count first), -> IDLE after counter reaches 0.
REQ-035 Timer == TIMEOUT_CYCLES in WR_DATA -> IDLE, xfer_err pulse, one in_wr with in_eop=1, in_be=4'b0000 terminates the partial packet.
REQ-036 Outputs other than in_* and xfer_err SHALL be combinational from state/counter; in_* and xfer_err registered.

Reset
REQ-037 reset_n low SHALL asynchronously force state IDLE, counter/timer 0, all outputs 0 (dma_data_to_cpci 0).
REQ-038 Reset mid-transfer SHALL abandon the transfer without drain, eop, or xfer_err.

Verification
REQ-039 pkt_len=61, dma_rd_req, 16 dma_rd_en -> length word 0x3D, then 16 data words, 16 pkt_rd, dma_rd_last on 16th, IDLE.
REQ-040 dma_wr_size=7 at start, 2 dma_wr_vld -> 2 in_wr, second with in_eop=1, in_be=0111; first in_be=1111.
REQ-041 dma_rd_req and dma_wr_start same cycle (size 8) -> WR_DATA entered, cpci_rd_rdy low until write completes.
REQ-042 Read of 10 words, stall after 3 dma_rd_en for 1023 cycles -> xfer_err pulse, 7 further pkt_rd cycles, IDLE.
REQ-043 dma_wr_size=0 -> xfer_err one cycle, no in_wr; in_full=1 -> dma_wr_start ignored.
REQ-044 reset_n low during WR_DATA -> immediate IDLE, no in_wr/in_eop, all outputs 0.

Source files
------------

// File: rtl/cnet_dma_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cnet_dma_xfer_ctrl
// Description : CPCI DMA transfer controller. Moves one egress packet to the
//               CPCI bus (length word first, then data) or one CPCI write into
//               the ingress path. An idle timer aborts stalled transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module cnet_dma_xfer_ctrl #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  // egress queue (show-ahead)
  input  logic        pkt_avail,
  input  logic [10:0] pkt_len,
  input  logic [31:0] pkt_data,
  output logic        pkt_rd,
  // CPCI read side
  output logic        cpci_rd_rdy,
  input  logic        dma_rd_req,
  input  logic        dma_rd_en,
  output logic [31:0] dma_data_to_cpci,
  output logic        dma_rd_last,
  // CPCI write side
  input  logic        dma_wr_start,
  input  logic [10:0] dma_wr_size,
  input  logic        dma_wr_vld,
  input  logic [31:0] dma_data_frm_cpci,
  output logic        cpci_wr_rdy,
  // ingress path
  input  logic        in_full,
  output logic        in_wr,
  output logic [31:0] in_data,
  output logic        in_eop,
  output logic [3:0]  in_be,
  // status
  output logic        xfer_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_LEN  = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_DATA = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  localparam logic [9:0] C_TIMEOUT = 10'(TIMEOUT_CYCLES);

  state_t      r_state, w_state_nxt;
  logic [8:0]  r_cnt, w_cnt_nxt;
  logic [9:0]  r_timer, w_timer_nxt;
  logic [3:0]  r_last_be, w_last_be_nxt;
  logic        w_in_wr_nxt, w_in_eop_nxt, w_err_nxt;
  logic [31:0] w_in_data_nxt;
  logic [3:0]  w_in_be_nxt;
  logic        w_timeout;

  // Words needed to carry len bytes, rounding a partial trailing word up.
  function automatic logic [8:0] word_cnt(input logic [10:0] len);
    return len[10:2] + {8'd0, |len[1:0]};
  endfunction

  // Byte enables of the final word, from the byte count modulo 4.
  function automatic logic [3:0] tail_be(input logic [1:0] rem);
    case (rem)
      2'b01:   return 4'b0001;
      2'b10:   return 4'b0011;
      2'b11:   return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  // Ready flags are forced low while reset is held so every output reads 0.
  assign cpci_rd_rdy = reset_n && (r_state == S_IDLE) && pkt_avail && (pkt_len != 11'd0);
  assign cpci_wr_rdy = reset_n && (r_state == S_IDLE) && !in_full;
  assign w_timeout   = (r_timer == C_TIMEOUT);

  // Read-side outputs decoded straight from state and counter.
  always_comb begin
    pkt_rd           = 1'b0;
    dma_data_to_cpci = 32'd0;
    dma_rd_last      = 1'b0;
    case (r_state)
      S_RD_LEN: dma_data_to_cpci = {21'd0, pkt_len};
      S_RD_DATA: begin
        dma_data_to_cpci = pkt_data;
        pkt_rd           = dma_rd_en;
        dma_rd_last      = (r_cnt == 9'd1);
      end
      S_DRAIN:  pkt_rd = (r_cnt != 9'd0);
      default: ;
    endcase
  end

  // Next-state, counter, idle-timer and registered-output computation.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_timer_nxt   = 10'd0;
    w_last_be_nxt = r_last_be;
    w_in_wr_nxt   = 1'b0;
    w_in_data_nxt = 32'd0;
    w_in_eop_nxt  = 1'b0;
    w_in_be_nxt   = 4'b0000;
    w_err_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A write start wins; a simultaneous read request is dropped.
        if (dma_wr_start && cpci_wr_rdy) begin
          if (dma_wr_size == 11'd0) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt   = S_WR_DATA;
            w_cnt_nxt     = word_cnt(dma_wr_size);
            w_last_be_nxt = tail_be(dma_wr_size[1:0]);
          end
        end else if (dma_rd_req && cpci_rd_rdy) begin
          w_state_nxt = S_RD_LEN;
        end
      end
      S_RD_LEN: begin
        if (dma_rd_en) begin
          w_state_nxt = S_RD_DATA;
          w_cnt_nxt   = word_cnt(pkt_len);
        end else if (w_timeout) begin
          // Length never fetched: still flush the whole packet.
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = word_cnt(pkt_len);
          w_err_nxt   = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 10'd1;
        end
      end
      S_RD_DATA: begin
        if (dma_rd_en) begin
          w_cnt_nxt = r_cnt - 9'd1;
          if (r_cnt <= 9'd1) w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_state_nxt = S_DRAIN;
          w_err_nxt   = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 10'd1;
        end
      end
      S_WR_DATA: begin
        if (dma_wr_vld) begin
          w_in_wr_nxt   = 1'b1;
          w_in_data_nxt = dma_data_frm_cpci;
          w_in_eop_nxt  = (r_cnt == 9'd1);
          w_in_be_nxt   = (r_cnt == 9'd1) ? r_last_be : 4'b1111;
          w_cnt_nxt     = r_cnt - 9'd1;
          if (r_cnt <= 9'd1) w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          // Close the partial packet with an empty end-of-packet word.
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = 9'd0;
          w_err_nxt    = 1'b1;
          w_in_wr_nxt  = 1'b1;
          w_in_eop_nxt = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 10'd1;
        end
      end
      S_DRAIN: begin
        if (r_cnt != 9'd0) w_cnt_nxt = r_cnt - 9'd1;
        if (r_cnt <= 9'd1) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 9'd0;
      end
    endcase
  end

  // State, counter, timer and registered outputs with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 9'd0;
      r_timer   <= 10'd0;
      r_last_be <= 4'b0000;
      in_wr     <= 1'b0;
      in_data   <= 32'd0;
      in_eop    <= 1'b0;
      in_be     <= 4'b0000;
      xfer_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timer   <= w_timer_nxt;
      r_last_be <= w_last_be_nxt;
      in_wr     <= w_in_wr_nxt;
      in_data   <= w_in_data_nxt;
      in_eop    <= w_in_eop_nxt;
      in_be     <= w_in_be_nxt;
      xfer_err  <= w_err_nxt;
    end
  end

endmodule
`default_nettype wire
